pps_period_meter: RTL
=====================

Name: pps_period_meter

Overview:
Measures the period of a 1 Hz pulse, either a mux output or the divided KG 1 Hz. The count is in clk (50 MHz) cycles, so the MPU can see oscillator frequency error directly.
- Sits downstream of the mux_signal tuning path, next to the intervalometers.
- Hangs on the same synchronised parallel bus: write strobe from the wr decoder, byte read strobes from the rd decoder, tri-state 8-bit Data.
- Adds loss-of-signal detection and a coherent multi-byte readout.

Parameters:
CNT_W, 32, period counter width (bits, multiple of 8, max 32)
TIMEOUT, 75000000, cycles without an edge before the input is declared lost (1.5 s @ 50 MHz)
SYNC_STAGES, 2, synchroniser depth for pps_in

Ports:
clk  input  1  50 MHz system clock
rst_n_wire  input  1  asynchronous active-low reset
pps_in  input  1  asynchronous 1 Hz pulse, pulse width ≥ 2 clk
clr  input  1  write strobe (level, multi-cycle); clears measurement and flags
rd_byte  input  5  read strobes; [3:0] period bytes 0..3 (LSB first), [4] status byte
data  inout  8  bus; driven only while any rd_byte bit is high, else Z
new_irq  output  1  one-clk pulse on each captured period

Behaviour:
Reset values:
- Counter, period, shadow = 0; flags = 0; armed = 0.
- new_irq = 0; data = Z.

Input conditioning:
- pps_in passes through SYNC_STAGES flops.
- A rising edge is sync_q & ~sync_q_d (one clk).

Counter:
- cnt increments every clk.
- cnt saturates at all-ones and sets ovf.

State machine IDLE / ARMED (clr edge = first cycle of clr high, registered):
- IDLE: edge → ARMED, cnt ← 1, no capture.
- ARMED: edge → period ← cnt, cnt ← 1, valid ← 1, newf ← 1, new_irq = 1 for that cycle, lost ← 0.
- ARMED: cnt == TIMEOUT with no edge that cycle → IDLE, lost ← 1; valid holds its last value.
- Any state: clr edge → IDLE, cnt ← 0, period ← 0, valid/lost/ovf/newf ← 0.

Simultaneous events:
- clr edge and pps edge in the same cycle: clr wins, no capture.
- pps edge on the TIMEOUT cycle: the edge wins (capture, no lost).

Period meaning:
- Number of clk cycles between successive synchronised edges.
- Nominal 50000000 = 0x02FAF080.

Readout coherence:
- First cycle of rd_byte[0] high (registered rising detect): shadow ← period, newf ← 0.
- Bytes 0..3 drive shadow[8k+7:8k], valid from the 2nd strobe cycle. Decoder strobes span many clk, so this is met.
- Captures during a read sequence do not disturb shadow.
- Bytes above CNT_W/8 read 0x00.

Status byte (rd_byte[4]):
- {4'b0, newf, ovf, lost, valid}, read live, no side effect.

Bus drive:
- If multiple rd_byte bits are high, the lowest index wins.
- data is Z within 1 clk after all strobes fall.

Reset mid-measurement:
- Immediate return to reset values; the next edge only re-arms.

Decomposition:
- Shared package: status bit indices (ST_VALID=0, ST_LOST=1, ST_OVF=2, ST_NEW=3), state encoding (IDLE, ARMED), default TIMEOUT constant.
- One sub-module, edge_sync: SYNC_STAGES synchroniser plus rising-edge pulse. It is reusable for the intervalometer inputs.
- Byte mux and tri-state stay in the top of this block.

Test Plan:
1. Reset, then edges 50000000 clk apart (sim: TIMEOUT=300, edges every 200) → 1st edge no irq; 2nd edge new_irq one cycle; read bytes 0..1 = 0xC8,0x00; status = 0x09.
2. Read byte0, then an edge arrives before byte1..3 are read → bytes 1..3 come from the old shadow; status newf = 0 after byte0 read; next byte0 read returns the new period.
3. Stop edges after arming → at cnt == 300 status = 0x02 (lost; valid was 0) or 0x03 if previously valid; next edge gives no capture; the following edge captures again and lost clears.
4. Edge exactly on the TIMEOUT cycle → capture period = 300, lost stays 0; clr on the same cycle as an edge → no irq, status 0x00.
5. CNT_W=8, edges 300 apart with TIMEOUT=1000 → ovf = 1, period = 0xFF, status = 0x0D; clr → 0x00.
6. Assert rst_n_wire low mid-period and mid-read → data = Z, status 0x00 after release; 1st edge arms only.

Source files
------------

// File: rtl/pps_period_meter_pkg.sv
// Shared definitions for the 1 Hz period meter: status bit positions,
// measurement state encoding and the default loss-of-signal timeout.
package pps_period_meter_pkg;

  localparam int ST_VALID = 0;
  localparam int ST_LOST  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_NEW   = 3;

  localparam int DEFAULT_TIMEOUT = 75000000;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  typedef struct packed {
    state_t state;
    logic   data_oe;
  } dbg_t;

endpackage

// File: rtl/pps_period_meter_if.sv
// Strobe side of the synchronised parallel bus as seen by the period meter.
// A read strobe is a level held for many clk; the meter drives data while any strobe is high.
interface pps_period_meter_if;
  logic       clr;
  logic [4:0] rd_byte;
  logic       new_irq;

  modport master (output clr, output rd_byte, input new_irq);
  modport slave  (input clr, input rd_byte, output new_irq);
endinterface

// File: rtl/pps_period_meter_edge_sync.sv
// Multi-flop synchroniser for an asynchronous input plus a one-clk rising-edge pulse.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n_wire,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              sync_q_d;

  always_ff @(posedge clk or negedge rst_n_wire) begin
    if (!rst_n_wire) begin
      sync_q   <= '0;
      sync_q_d <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_q_d <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~sync_q_d;

endmodule

// File: rtl/pps_period_meter.sv
// Measures the clk-cycle period of a 1 Hz pulse, flags loss of signal and counter
// saturation, and offers a coherent byte-wise readout on the tri-state data bus.
module pps_period_meter
  import pps_period_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n_wire,
  input  logic                      pps_in,
  pps_period_meter_if.slave         bus,
  inout  wire  [7:0]                data,
  output dbg_t                      dbg
);

  state_t           state;
  logic [CNT_W-1:0] cnt, period, shadow;
  logic             valid, lost, ovf, newf;
  logic             clr_q, rd0_q, new_irq_q;
  logic             pps_rise, clr_edge, rd0_edge;
  logic [31:0]      cnt_ext, shadow_ext;
  logic [7:0]       status, rd_data;
  logic             data_oe;

  edge_sync #(.STAGES(SYNC_STAGES)) u_pps_sync (
    .clk        (clk),
    .rst_n_wire (rst_n_wire),
    .async_in   (pps_in),
    .rise       (pps_rise)
  );

  assign clr_edge = bus.clr & ~clr_q;
  assign rd0_edge = bus.rd_byte[0] & ~rd0_q;

  always_comb begin
    cnt_ext                = '0;
    cnt_ext[CNT_W-1:0]     = cnt;
    shadow_ext             = '0;
    shadow_ext[CNT_W-1:0]  = shadow;
  end

  // Order matters: the byte-0 read clears newf first so a capture in the same cycle re-sets it,
  // and a clr edge overrides everything, including a coincident pps edge.
  always_ff @(posedge clk or negedge rst_n_wire) begin
    if (!rst_n_wire) begin
      state     <= IDLE;
      cnt       <= '0;
      period    <= '0;
      shadow    <= '0;
      valid     <= 1'b0;
      lost      <= 1'b0;
      ovf       <= 1'b0;
      newf      <= 1'b0;
      clr_q     <= 1'b0;
      rd0_q     <= 1'b0;
      new_irq_q <= 1'b0;
    end else begin
      clr_q     <= bus.clr;
      rd0_q     <= bus.rd_byte[0];
      new_irq_q <= 1'b0;
      if (rd0_edge) begin
        shadow <= period;
        newf   <= 1'b0;
      end
      if (clr_edge) begin
        state  <= IDLE;
        cnt    <= '0;
        period <= '0;
        valid  <= 1'b0;
        lost   <= 1'b0;
        ovf    <= 1'b0;
        newf   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (pps_rise) begin
              state <= ARMED;
              cnt   <= CNT_W'(1);
            end
          end
          ARMED: begin
            if (pps_rise) begin
              period    <= cnt;
              cnt       <= CNT_W'(1);
              valid     <= 1'b1;
              newf      <= 1'b1;
              lost      <= 1'b0;
              new_irq_q <= 1'b1;
            end else if (cnt_ext == 32'(TIMEOUT)) begin
              state <= IDLE;
              lost  <= 1'b1;
            end else if (cnt == '1) begin
              ovf <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Lowest strobe index wins; bytes beyond CNT_W read as zero via shadow_ext.
  always_comb begin
    status           = 8'h00;
    status[ST_VALID] = valid;
    status[ST_LOST]  = lost;
    status[ST_OVF]   = ovf;
    status[ST_NEW]   = newf;
    rd_data          = 8'h00;
    if (bus.rd_byte[0])      rd_data = shadow_ext[7:0];
    else if (bus.rd_byte[1]) rd_data = shadow_ext[15:8];
    else if (bus.rd_byte[2]) rd_data = shadow_ext[23:16];
    else if (bus.rd_byte[3]) rd_data = shadow_ext[31:24];
    else if (bus.rd_byte[4]) rd_data = status;
  end

  assign data_oe     = |bus.rd_byte;
  assign data        = data_oe ? rd_data : 8'hzz;
  assign bus.new_irq = new_irq_q;
  assign dbg.state   = state;
  assign dbg.data_oe = data_oe;

endmodule
